// File: rtl/small_mips_pkg.sv
// Shared Small_MIPS definitions: opcode/funct encodings, the execute-stage
// sequencer state type and small decode helpers used by the execute stage.
package small_mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_NOP   = 6'b000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_WB   = 2'd3
    } exec_state_t;

    // Instructions whose second ALU operand is the sign-extended immediate.
    function automatic logic uses_imm(input logic [5:0] opcode);
        return (opcode == OP_ADDI) || (opcode == OP_ADDIU) ||
               (opcode == OP_LW)   || (opcode == OP_SW);
    endfunction

    // Instructions whose destination register is the rt field rather than rd.
    function automatic logic writes_rt(input logic [5:0] opcode);
        return (opcode == OP_ADDI) || (opcode == OP_ADDIU) || (opcode == OP_LW);
    endfunction

endpackage

// File: rtl/exec_sequencer.sv
// Multi-cycle execute-stage controller for Small_MIPS.
// Accepts one decoded instruction at a time, drives the external ALU from
// latched operands, sequences LW/SW data-memory accesses and presents a
// one-cycle register-file writeback.
// Optional feature: define EXEC_SEQ_MEM_TIMEOUT_EN to abort a memory access
// that has not been acknowledged within MEM_TIMEOUT cycles (err pulses).
module exec_sequencer
    import small_mips_pkg::*;
#(
    parameter int DW          = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    in_opcode,
    input  logic [5:0]    in_funct,
    input  logic [4:0]    in_shamt,
    input  logic [DW-1:0] in_rs_val,
    input  logic [DW-1:0] in_rt_val,
    input  logic [DW-1:0] in_imm,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rt,
    output logic [DW-1:0] alu_op1,
    output logic [DW-1:0] alu_op2,
    output logic [5:0]    alu_opcode,
    output logic [5:0]    alu_ar_op,
    output logic [4:0]    alu_shamt,
    input  logic [DW-1:0] alu_result,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          wb_valid,
    output logic [4:0]    wb_rd,
    output logic [DW-1:0] wb_data,
    output logic          busy,
    output logic          err
);

    exec_state_t   state;
    exec_state_t   state_next;

    logic [5:0]    opcode_q;
    logic [5:0]    funct_q;
    logic [4:0]    shamt_q;
    logic [DW-1:0] rs_q;
    logic [DW-1:0] rt_val_q;
    logic [DW-1:0] imm_q;
    logic [4:0]    rd_q;
    logic [4:0]    rt_idx_q;
    logic [DW-1:0] res_q;

    logic          mem_timeout;
    logic          in_wb;
    logic [4:0]    wb_dest;

`ifdef EXEC_SEQ_MEM_TIMEOUT_EN
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] mem_cnt;
    logic          err_q;

    // Count cycles spent in MEM; cleared whenever the sequencer is elsewhere.
    always_ff @(posedge clk) begin
        if (rst || (state != ST_MEM)) begin
            mem_cnt <= '0;
        end else begin
            mem_cnt <= mem_cnt + CW'(1);
        end
    end

    // An ack in the final allowed cycle takes priority over the timeout.
    assign mem_timeout = (state == ST_MEM) && !mem_ack &&
                         (mem_cnt == CW'(MEM_TIMEOUT - 1));

    // One-cycle error pulse in the cycle after the access is abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= mem_timeout;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout_cfg;

    assign mem_timeout        = 1'b0;
    assign err                = 1'b0;
    assign unused_timeout_cfg = ^MEM_TIMEOUT;
`endif

    // Next-state selection for the IDLE -> EXEC -> (MEM) -> (WB) sequence.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if ((opcode_q == OP_LW) || (opcode_q == OP_SW)) begin
                    state_next = ST_MEM;
                end else if (((opcode_q == OP_RTYPE) && (funct_q == FN_ADDU)) ||
                             (opcode_q == OP_ADDI) || (opcode_q == OP_ADDIU)) begin
                    state_next = ST_WB;
                end else begin
                    // NOP, JR and unsupported encodings retire without writeback.
                    state_next = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    state_next = (opcode_q == OP_LW) ? ST_WB : ST_IDLE;
                end else if (mem_timeout) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WB: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus instruction latch and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            opcode_q <= '0;
            funct_q  <= '0;
            shamt_q  <= '0;
            rs_q     <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
            rd_q     <= '0;
            rt_idx_q <= '0;
            res_q    <= '0;
        end else begin
            state <= state_next;
            if ((state == ST_IDLE) && in_valid) begin
                opcode_q <= in_opcode;
                funct_q  <= in_funct;
                shamt_q  <= in_shamt;
                rs_q     <= in_rs_val;
                rt_val_q <= in_rt_val;
                imm_q    <= in_imm;
                rd_q     <= in_rd;
                rt_idx_q <= in_rt;
            end
            if (state == ST_EXEC) begin
                res_q <= alu_result;
            end else if ((state == ST_MEM) && mem_ack && (opcode_q == OP_LW)) begin
                res_q <= mem_rdata;
            end
        end
    end

    assign in_ready   = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);

    assign alu_op1    = rs_q;
    assign alu_op2    = uses_imm(opcode_q) ? imm_q : rt_val_q;
    assign alu_opcode = opcode_q;
    assign alu_ar_op  = funct_q;
    assign alu_shamt  = shamt_q;

    assign mem_req    = (state == ST_MEM);
    assign mem_we     = mem_req && (opcode_q == OP_SW);
    assign mem_addr   = mem_req ? res_q : '0;
    assign mem_wdata  = mem_req ? rt_val_q : '0;

    assign in_wb      = (state == ST_WB);
    assign wb_dest    = writes_rt(opcode_q) ? rt_idx_q : rd_q;
    assign wb_valid   = in_wb && (wb_dest != 5'd0);
    assign wb_rd      = in_wb ? wb_dest : 5'd0;
    assign wb_data    = in_wb ? res_q : '0;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: directed cases followed by random
// instruction streams, checked against a behavioural model of the sequencer.
`timescale 1ns/1ps
module tb_exec_sequencer;

`ifdef EXEC_SEQ_MEM_TIMEOUT_EN
    localparam int TB_TO = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TB_TO = 16;
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_ADDIU = 6'b001001;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_NOP   = 6'b000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [5:0]  in_funct;
    logic [4:0]  in_shamt;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;
    logic [4:0]  in_rt;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [5:0]  alu_opcode;
    logic [5:0]  alu_ar_op;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
    logic        err;

    exec_sequencer #(.DW(32), .MEM_TIMEOUT(TB_TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct(in_funct), .in_shamt(in_shamt),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
        .in_rd(in_rd), .in_rt(in_rt),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
        .alu_ar_op(alu_ar_op), .alu_shamt(alu_shamt), .alu_result(alu_result),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // External ALU stand-in: an adder, enough for the add-class instructions.
    assign alu_result = alu_op1 + alu_op2;

    typedef struct { logic [31:0] op1; logic [31:0] op2; logic [5:0] opc; logic [5:0] fn; logic [4:0] sh; } alu_exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic we; } mem_exp_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_exp_t;

    alu_exp_t exp_alu[$];
    mem_exp_t exp_mem[$];
    wb_exp_t  exp_wb[$];

    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] env_mem[logic [31:0]];

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    int err_exp = 0;
    int ack_lat = 0;
    bit no_ack = 1'b0;
    bit spurious = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory responder: acks after ack_lat waiting cycles, optional stray acks.
    initial begin
        int wcnt;
        mem_ack = 1'b0;
        mem_rdata = '0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (rst || !mem_req) begin
                wcnt = 0;
                mem_ack = spurious && !rst && ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end else if (!no_ack && (wcnt == ack_lat)) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    env_mem[mem_addr] = mem_wdata;
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : mem_init(mem_addr);
                end
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    // Monitor: compares DUT activity against the queued expectations.
    initial begin
        bit busy_prev;
        bit req_prev;
        bit cur_ok;
        mem_exp_t cur;
        alu_exp_t ea;
        wb_exp_t ew;
        busy_prev = 1'b0;
        req_prev = 1'b0;
        cur_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 1'b0;
                req_prev = 1'b0;
                cur_ok = 1'b0;
            end else begin
                if (busy && !busy_prev) begin
                    if (exp_alu.size() == 0) begin
                        chk("alu_unexpected_busy", {31'd0, busy}, 32'd0);
                    end else begin
                        ea = exp_alu.pop_front();
                        chk("alu_op1", alu_op1, ea.op1);
                        chk("alu_op2", alu_op2, ea.op2);
                        chk("alu_opcode", {26'd0, alu_opcode}, {26'd0, ea.opc});
                        chk("alu_ar_op", {26'd0, alu_ar_op}, {26'd0, ea.fn});
                        chk("alu_shamt", {27'd0, alu_shamt}, {27'd0, ea.sh});
                    end
                end
                if (mem_req) begin
                    if (!req_prev) begin
                        if (exp_mem.size() == 0) begin
                            chk("mem_unexpected_req", {31'd0, mem_req}, 32'd0);
                            cur_ok = 1'b0;
                        end else begin
                            cur = exp_mem.pop_front();
                            cur_ok = 1'b1;
                        end
                    end
                    if (cur_ok) begin
                        chk("mem_addr", mem_addr, cur.addr);
                        chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
                        chk("mem_wdata", mem_wdata, cur.wdata);
                    end
                end
                if (wb_valid) begin
                    if (exp_wb.size() == 0) begin
                        chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
                    end else begin
                        ew = exp_wb.pop_front();
                        chk("wb_rd", {27'd0, wb_rd}, {27'd0, ew.rd});
                        chk("wb_data", wb_data, ew.data);
                    end
                end
                if (err) err_seen++;
                busy_prev = busy;
                req_prev = mem_req;
            end
        end
    end

    // Reference model of one instruction: queues expectations, returns timing.
    task automatic model_push(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                              input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [4:0] rti, input int lat,
                              input bit nack, input bit commit,
                              output int exp_lat, output int exp_memc, output bit wb_exp);
        bit is_lw, is_sw, is_add, tmo;
        logic [31:0] addr, data;
        logic [4:0] dest;
        alu_exp_t ea;
        mem_exp_t em;
        wb_exp_t ew;
        is_lw  = (opc == T_LW);
        is_sw  = (opc == T_SW);
        is_add = ((opc == T_RTYPE) && (fn == F_ADDU)) || (opc == T_ADDI) || (opc == T_ADDIU);
        addr   = rs + imm;
        tmo    = (is_lw || is_sw) && nack && TO_EN;
        ea.op1 = rs;
        ea.op2 = (opc == T_ADDI || opc == T_ADDIU || is_lw || is_sw) ? imm : rt;
        ea.opc = opc;
        ea.fn  = fn;
        ea.sh  = sh;
        exp_alu.push_back(ea);
        if (is_lw || is_sw) begin
            em.addr = addr;
            em.wdata = rt;
            em.we = is_sw;
            exp_mem.push_back(em);
        end
        dest = (opc == T_RTYPE) ? rd : rti;
        data = '0;
        if (is_add) data = (opc == T_RTYPE) ? rs + rt : rs + imm;
        if (is_lw) data = ref_mem.exists(addr) ? ref_mem[addr] : mem_init(addr);
        wb_exp = commit && (is_add || (is_lw && !tmo)) && (dest != 5'd0);
        if (wb_exp) begin
            ew.rd = dest;
            ew.data = data;
            exp_wb.push_back(ew);
        end
        if (commit && is_sw && !tmo) ref_mem[addr] = rt;
        if (commit && tmo) err_exp++;
        if (is_lw || is_sw) begin
            exp_memc = tmo ? TB_TO : lat + 1;
            exp_lat  = tmo ? 2 + TB_TO : (is_lw ? 4 + lat : 3 + lat);
        end else begin
            exp_memc = 0;
            exp_lat  = is_add ? 3 : 2;
        end
    endtask

    task automatic drive_accept(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                                input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                                input logic [4:0] rd, input logic [4:0] rti);
        in_opcode = opc; in_funct = fn; in_shamt = sh;
        in_rs_val = rs; in_rt_val = rt; in_imm = imm;
        in_rd = rd; in_rt = rti;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_opcode = 6'($urandom); in_funct = 6'($urandom); in_shamt = 5'($urandom);
        in_rs_val = $urandom; in_rt_val = $urandom; in_imm = $urandom;
        in_rd = 5'($urandom); in_rt = 5'($urandom);
    endtask

    task automatic issue(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                         input logic [4:0] rd, input logic [4:0] rti, input int lat, input bit nack);
        int exp_lat, exp_memc, n, memc, wb_cyc;
        bit wb_exp, done;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("ready_wait", {31'd0, in_ready}, 32'd1);
            return;
        end
        model_push(opc, fn, sh, rs, rt, imm, rd, rti, lat, nack, 1'b1, exp_lat, exp_memc, wb_exp);
        ack_lat = lat;
        no_ack = nack;
        drive_accept(opc, fn, sh, rs, rt, imm, rd, rti);
        memc = 0;
        wb_cyc = -1;
        done = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (mem_req) memc++;
            if (wb_valid) wb_cyc = n;
            if (in_ready) done = 1'b1;
        end
        if (!done) begin
            chk("latency_bound", {31'd0, in_ready}, 32'd1);
        end else begin
            chk("ready_latency", n, exp_lat);
        end
        chk("mem_req_cycles", memc, exp_memc);
        chk("wb_cycle", wb_cyc, wb_exp ? exp_lat - 1 : -1);
        no_ack = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_alu_op1"}, alu_op1, 32'd0);
        chk({tag, "_alu_op2"}, alu_op2, 32'd0);
        chk({tag, "_alu_opcode"}, {26'd0, alu_opcode}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_lat, exp_memc, kind, gap, lat;
        bit wb_exp, nack;
        logic [5:0] opc, fn;
        logic [31:0] rs, imm;
        logic [4:0] rd;
        rst = 1'b1;
        in_valid = 1'b0;
        in_opcode = '0; in_funct = '0; in_shamt = '0;
        in_rs_val = '0; in_rt_val = '0; in_imm = '0;
        in_rd = '0; in_rt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // ADDU 5 + 7 -> r3
        issue(T_RTYPE, F_ADDU, 5'd0, 32'd5, 32'd7, 32'h0000_0abc, 5'd3, 5'd20, 0, 1'b0);
        // ADDIU wrap-around -> r9 = 0
        issue(T_ADDIU, 6'd17, 5'd0, 32'hFFFF_FFFF, 32'h1234_5678, 32'd1, 5'd4, 5'd9, 0, 1'b0);
        // LW from 0x104 with a three-cycle wait
        ref_mem[32'h104] = 32'hDEAD_BEEF;
        env_mem[32'h104] = 32'hDEAD_BEEF;
        issue(T_LW, 6'd0, 5'd0, 32'h100, 32'h0, 32'd4, 5'd0, 5'd6, 3, 1'b0);
        // SW acked in the first MEM cycle
        issue(T_SW, 6'd0, 5'd0, 32'h200, 32'h55, 32'd0, 5'd1, 5'd2, 0, 1'b0);
        // Writeback to r0 is suppressed; JR retires without writeback
        issue(T_RTYPE, F_ADDU, 5'd0, 32'd11, 32'd22, 32'd0, 5'd0, 5'd8, 0, 1'b0);
        issue(T_RTYPE, F_JR, 5'd0, 32'h400, 32'd0, 32'd0, 5'd31, 5'd31, 0, 1'b0);
        // Read back the stored word
        issue(T_LW, 6'd0, 5'd0, 32'h1F0, 32'h0, 32'h10, 5'd0, 5'd12, 1, 1'b0);

        if (TO_EN) begin
            issue(T_LW, 6'd0, 5'd0, 32'h300, 32'h0, 32'd8, 5'd0, 5'd5, 0, 1'b1);
            issue(T_SW, 6'd0, 5'd0, 32'h300, 32'h77, 32'd8, 5'd0, 5'd5, 0, 1'b1);
            issue(T_LW, 6'd0, 5'd0, 32'h300, 32'h0, 32'd8, 5'd0, 5'd5, TB_TO - 1, 1'b0);
        end

        // Reset in the middle of a memory wait
        model_push(T_LW, 6'd0, 5'd0, 32'h500, 32'h0, 32'd4, 5'd0, 5'd7, 0, 1'b1, 1'b0,
                   exp_lat, exp_memc, wb_exp);
        no_ack = 1'b1;
        drive_accept(T_LW, 6'd0, 5'd0, 32'h500, 32'h0, 32'd4, 5'd0, 5'd7);
        repeat (3) @(negedge clk);
        chk("midmem_req_before_reset", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_reset("midmem");
        rst = 1'b0;
        no_ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("midmem_no_restart", {31'd0, busy}, 32'd0);

        // Random instruction stream
        spurious = 1'b1;
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 8);
            fn = 6'($urandom);
            rs = $urandom;
            imm = $urandom;
            lat = $urandom_range(0, 4);
            nack = 1'b0;
            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            case (kind)
                0: begin opc = T_RTYPE; fn = F_ADDU; end
                1: opc = T_ADDI;
                2: opc = T_ADDIU;
                3, 4: begin
                    opc = (kind == 3) ? T_LW : T_SW;
                    rs = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
                    imm = 32'($urandom_range(0, 3)) * 4;
                    nack = TO_EN && ($urandom_range(0, 7) == 0);
                end
                5: begin opc = T_RTYPE; fn = F_JR; end
                6: begin opc = T_RTYPE; fn = F_NOP; end
                7: begin opc = T_RTYPE; fn = F_ADD; end
                default: opc = T_J;
            endcase
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            issue(opc, fn, 5'($urandom), rs, $urandom, imm, rd, 5'($urandom), lat, nack);
        end
        spurious = 1'b0;
        repeat (4) @(negedge clk);

        chk("alu_queue_drained", exp_alu.size(), 0);
        chk("mem_queue_drained", exp_mem.size(), 0);
        chk("wb_queue_drained", exp_wb.size(), 0);
        chk("err_pulse_count", err_seen, err_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
